// File: rtl/up_down_count.sv
// rtl/up_down_count.sv - free-running WIDTH-bit up/down counter with wrap pulse and end-of-range flags
module up_down_count #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             up_down,
   output logic [WIDTH-1:0] count,
   output logic             at_max,
   output logic             at_min,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   // wrap is decided from the pre-edge count, so it marks exactly the edge that rolled over
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         wrap  <= 1'b0;
      end else if (up_down) begin
         count <= count + ONE;
         wrap  <= &count;
      end else begin
         count <= count - ONE;
         wrap  <= ~|count;
      end
   end

   assign at_max = &count;
   assign at_min = ~|count;

endmodule

// File: tb/tb_up_down_count.sv
// tb/tb_up_down_count.sv - scoreboard bench for up_down_count against an arithmetic reference model
module tb_up_down_count;

   localparam int W = 4;
   localparam int M = 1 << W;

   logic         clk;
   logic         reset;
   logic         up_down;
   logic [W-1:0] count;
   logic         at_max;
   logic         at_min;
   logic         wrap;

   typedef struct {
      int count;
      int wrap;
   } exp_t;

   exp_t sb_q[$];
   int   model_count;
   int   tests;
   int   fails;

   up_down_count #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset   (reset),
      .up_down (up_down),
      .count   (count),
      .at_max  (at_max),
      .at_min  (at_min),
      .wrap    (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // reference: modular arithmetic on an integer, wrap when the step leaves [0, M-1]
   task automatic step(input bit dir, input bit release_reset);
      exp_t e;
      int   raw;
      @(negedge clk);
      #1;
      if (release_reset) begin
         reset = 1'b1;
      end
      up_down = ~dir;
      #1;
      up_down = dir;
      raw = dir ? model_count + 1 : model_count - 1;
      e.wrap = (raw < 0 || raw >= M) ? 1 : 0;
      e.count = (raw + M) % M;
      model_count = e.count;
      sb_q.push_back(e);
   endtask

   // monitor: every falling edge that finds a pending expectation checks the post-edge outputs
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("count", int'(count), e.count);
            check("wrap", int'(wrap), e.wrap);
            check("at_max", int'(at_max), (e.count == M - 1) ? 1 : 0);
            check("at_min", int'(at_min), (e.count == 0) ? 1 : 0);
         end
      end
   end

   task automatic settle_and_reset();
      @(negedge clk);
      #2;
      check("queue_drained", sb_q.size(), 0);
      reset = 1'b0;
      model_count = 0;
      #1;
      check("async_rst_count", int'(count), 0);
      check("async_rst_wrap", int'(wrap), 0);
      check("async_rst_at_min", int'(at_min), 1);
      check("async_rst_at_max", int'(at_max), 0);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      model_count = 0;
      reset = 1'b0;
      up_down = 1'b1;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_count", int'(count), 0);
      check("rst_at_min", int'(at_min), 1);
      check("rst_at_max", int'(at_max), 0);
      check("rst_wrap", int'(wrap), 0);

      // count up 1..5, continue to 14, then 15 and wrap to 0
      step(1'b1, 1'b1);
      for (int i = 0; i < 13; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      // down through 0 with a down wrap
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      // to 7, then up/down/up direction changes, then to 9
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);

      @(negedge clk);
      #2;
      check("pre_async_count", int'(count), 9);
      reset = 1'b0;
      model_count = 0;
      #1;
      check("async_mid_count", int'(count), 0);
      check("async_mid_wrap", int'(wrap), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("hold_rst_count", int'(count), 0);
      check("hold_rst_at_min", int'(at_min), 1);

      // first edge after release going down must wrap to all-ones
      step(1'b0, 1'b1);
      for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)), 1'b0);

      settle_and_reset();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/up_down_count.md
UP_DOWN_COUNT -- requirements
Module: up_down_count

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; legal range 2..32.
REQ-002 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 Port reset, input, 1, asynchronous active-low reset: reset=0 clears all state immediately, independent of clk.
REQ-004 Port up_down, input, 1, direction select: 1 = count up, 0 = count down.
REQ-005 Port count, output, WIDTH, current counter value, driven directly from a register.
REQ-006 Port at_max, output, 1, high while count equals all-ones (15 for WIDTH=4).
REQ-007 Port at_min, output, 1, high while count equals zero.
REQ-008 Port wrap, output, 1, registered one-cycle pulse marking a wrap-around on the most recent edge.

Function
REQ-009 With reset=1, each rising clk edge updates count unconditionally; there is no hold or enable state.
REQ-010 up_down=1 at an edge: count <= count + 1, modulo 2^WIDTH.
REQ-011 up_down=0 at an edge: count <= count - 1, modulo 2^WIDTH.
REQ-012 up_down is sampled only at the rising edge; changes between edges have no effect until the next edge.
REQ-013 Latency: the new count is visible one clk edge after the sampling edge; there is no combinational path from up_down to count.
REQ-014 Up wrap: count=all-ones with up_down=1 gives count=0 and wrap=1 for the following cycle.
REQ-015 Down wrap: count=0 with up_down=0 gives count=all-ones and wrap=1 for the following cycle.
REQ-016 wrap=0 after every edge that produced no wrap-around; wrap never stays high for two cycles unless consecutive edges both wrap.
REQ-017 at_max and at_min are combinational decodes of the count register only; they are never both high.
REQ-018 A direction change takes effect at the next edge with no dead cycle; for example 5 up then down gives 6 then 5.
REQ-019 Count arithmetic is carried out in exactly WIDTH bits; no overflow or carry bit is retained beyond the wrap pulse.

Reset
REQ-020 While reset=0: count=0, wrap=0, at_min=1, at_max=0, regardless of clk or up_down.
REQ-021 Reset assertion mid-count clears count to 0 asynchronously, without waiting for a clock edge.
REQ-022 After reset deasserts (0->1), the first rising edge with reset=1 performs a normal count step from 0: up gives 1, down gives all-ones with wrap=1.
REQ-023 No register in the block has an undefined value after reset; all outputs are known from reset assertion onward.

Verification
REQ-024 Reset: hold reset=0 for 2 edges with up_down=1 -> count=0, at_min=1, wrap=0.
REQ-025 Count up: release reset, up_down=1 for 5 edges -> count=1,2,3,4,5.
REQ-026 Up wrap: count=14, up_down=1 for 2 edges -> count=15 (at_max=1), then 0 with wrap=1 for one cycle.
REQ-027 Count down and down wrap: count=2, up_down=0 for 3 edges -> count=1, 0 (at_min=1), then 15 with wrap=1.
REQ-028 Direction change: count=7, edge up, edge down, edge up -> count=8, 7, 8; wrap stays 0.
REQ-029 Asynchronous reset: count=9, drive reset=0 between clock edges -> count=0 before the next rising edge.
